// File: rtl/ex3_to_bcd_serial_if.sv
// Serial Excess-3 link plus decoded-digit outputs of the Excess-3 to BCD decoder.
interface ex3_to_bcd_serial_if;
  logic       En;        // bit strobe
  logic       X;         // serial Excess-3 bit, LSB first
  logic       S;         // decoded BCD bit (Mealy)
  logic       V;         // invalid-code flag on the 4th bit (Mealy)
  logic [3:0] Digit;     // last completed BCD digit
  logic       Done;      // one-cycle pulse per completed digit
  logic       DErr;      // invalid flag of the digit just completed
  logic       WordDone;  // one-cycle pulse per completed word
  logic       Err;       // sticky invalid flag for the current/last word

  modport master (
    output En, X,
    input  S, V, Digit, Done, DErr, WordDone, Err
  );

  modport slave (
    input  En, X,
    output S, V, Digit, Done, DErr, WordDone, Err
  );
endinterface

// File: rtl/ex3_to_bcd_serial.sv
// Bit-serial Excess-3 to BCD decoder. Subtracts 0011 from each LSB-first digit
// with a running borrow, emits every decoded bit combinationally, and registers
// the completed digit plus per-digit and per-word error flags on the falling edge.
module ex3_to_bcd_serial #(
  parameter int NDIG = 1  // digits per word, 1..8
) (
  input logic                 CLK,
  input logic                 ClrN,
  ex3_to_bcd_serial_if.slave  bus
);

  localparam int DCW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [DCW-1:0] DC_LAST = DCW'(NDIG - 1);

  // Registered state
  logic [1:0]     bc_q, bc_d;            // bit index within the digit
  logic [DCW-1:0] dc_q, dc_d;            // digit index within the word
  logic           borrow_q, borrow_d;
  logic [2:0]     in_sh_q, in_sh_d;      // raw Excess-3 bits received so far
  logic [2:0]     out_sh_q, out_sh_d;    // decoded BCD bits produced so far
  logic [3:0]     digit_q, digit_d;
  logic           done_q, done_d;
  logic           derr_q, derr_d;
  logic           word_done_q, word_done_d;
  logic           err_q, err_d;

  // Bit-level datapath
  logic       sub_k;
  logic       s_bit;
  logic       b_next;
  logic       last_bit;
  logic [3:0] code;
  logic       v_bit;

  // Serial subtract of 0011: subtrahend is 1 on bits 0 and 1 only.
  always_comb begin
    sub_k    = ~bc_q[1];
    last_bit = (bc_q == 2'd3);
    s_bit    = bus.En & (bus.X ^ sub_k ^ borrow_q);
    b_next   = (~bus.X & (sub_k | borrow_q)) | (sub_k & borrow_q);
    code     = {bus.X, in_sh_q};
    v_bit    = bus.En & last_bit & ((code < 4'd3) | (code > 4'd12));
  end

  assign bus.S        = s_bit;
  assign bus.V        = v_bit;
  assign bus.Digit    = digit_q;
  assign bus.Done     = done_q;
  assign bus.DErr     = derr_q;
  assign bus.WordDone = word_done_q;
  assign bus.Err      = err_q;

  // Next-state: accumulate bits, then close out the digit and word on bit 3.
  always_comb begin
    // NOTE: every _d gets a default before any branch, so no path leaves one unassigned and infers a latch.
    bc_d        = bc_q;
    dc_d        = dc_q;
    borrow_d    = borrow_q;
    in_sh_d     = in_sh_q;
    out_sh_d    = out_sh_q;
    digit_d     = digit_q;
    err_d       = err_q;
    done_d      = 1'b0;
    derr_d      = 1'b0;
    word_done_d = 1'b0;

    if (bus.En) begin
      if (!last_bit) begin
        for (int i = 0; i < 3; i++) begin
          if (bc_q == 2'(i)) begin
            in_sh_d[i]  = bus.X;
            out_sh_d[i] = s_bit;
          end
        end
        borrow_d = b_next;
        bc_d     = bc_q + 2'd1;
      end else begin
        digit_d  = v_bit ? 4'hF : {s_bit, out_sh_q};
        done_d   = 1'b1;
        derr_d   = v_bit;
        bc_d     = 2'd0;
        borrow_d = 1'b0;
        if (dc_q == DC_LAST) begin
          dc_d        = '0;
          word_done_d = 1'b1;
        end else begin
          dc_d = dc_q + DCW'(1);
        end
        // First digit of a word restarts the error window.
        err_d = (dc_q == '0) ? v_bit : (err_q | v_bit);
      end
    end
  end

  // State register: falling-edge update, asynchronous active-low clear.
  always_ff @(negedge CLK or negedge ClrN) begin
    if (!ClrN) begin
      bc_q        <= 2'd0;
      dc_q        <= '0;
      borrow_q    <= 1'b0;
      in_sh_q     <= 3'd0;
      out_sh_q    <= 3'd0;
      digit_q     <= 4'd0;
      done_q      <= 1'b0;
      derr_q      <= 1'b0;
      word_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the values from before this edge.
      bc_q        <= bc_d;
      dc_q        <= dc_d;
      borrow_q    <= borrow_d;
      in_sh_q     <= in_sh_d;
      out_sh_q    <= out_sh_d;
      digit_q     <= digit_d;
      done_q      <= done_d;
      derr_q      <= derr_d;
      word_done_q <= word_done_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_ex3_to_bcd_serial.sv
// Directed bench for the Excess-3 to BCD decoder: a single-digit-word instance
// for digit decoding, gaps and reset, and a two-digit-word instance for word flags.
module tb_ex3_to_bcd_serial;

  logic CLK = 1'b0;
  logic ClrN;
  logic en;
  logic x;
  logic sel;  // 0: NDIG=1 instance, 1: NDIG=2 instance

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  ex3_to_bcd_serial_if if1 ();
  ex3_to_bcd_serial_if if2 ();

  assign if1.En = en & ~sel;
  assign if1.X  = x;
  assign if2.En = en & sel;
  assign if2.X  = x;

  ex3_to_bcd_serial #(.NDIG(1)) dut1 (.CLK(CLK), .ClrN(ClrN), .bus(if1));
  ex3_to_bcd_serial #(.NDIG(2)) dut2 (.CLK(CLK), .ClrN(ClrN), .bus(if2));

  logic       obs_s, obs_v, obs_done, obs_derr, obs_wd, obs_err;
  logic [3:0] obs_digit;

  always_comb begin
    obs_s     = sel ? if2.S        : if1.S;
    obs_v     = sel ? if2.V        : if1.V;
    obs_digit = sel ? if2.Digit    : if1.Digit;
    obs_done  = sel ? if2.Done     : if1.Done;
    obs_derr  = sel ? if2.DErr     : if1.DErr;
    obs_wd    = sel ? if2.WordDone : if1.WordDone;
    obs_err   = sel ? if2.Err      : if1.Err;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Drive one bit at the rising edge; it is consumed at the following falling edge.
  task automatic send_bit(input logic b, output logic s, output logic v);
    @(posedge CLK);
    en = 1'b1;
    x  = b;
    #1;
    s = obs_s;
    v = obs_v;
  endtask

  // One idle (En=0) cycle, sampled well after the preceding falling edge.
  task automatic idle;
    @(posedge CLK);
    en = 1'b0;
    x  = 1'b1;
    #1;
  endtask

  task automatic check_digit_outputs(input string tag, input logic [3:0] exp_dig,
                                     input logic exp_derr, input logic exp_wd,
                                     input logic exp_err);
    check({tag, ".digit"}, 32'(obs_digit), 32'(exp_dig));
    check({tag, ".done"},  32'(obs_done),  32'd1);
    check({tag, ".derr"},  32'(obs_derr),  32'(exp_derr));
    check({tag, ".wd"},    32'(obs_wd),    32'(exp_wd));
    check({tag, ".err"},   32'(obs_err),   32'(exp_err));
  endtask

  // Send a whole digit back-to-back; code is the Excess-3 value, sent LSB first.
  task automatic send_digit(input string tag, input logic [3:0] code,
                            input logic [3:0] exp_dig, input logic exp_v,
                            input logic exp_wd, input logic exp_err);
    logic [3:0] s_nib;
    logic       v_early;
    logic       s;
    logic       v;
    v_early = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send_bit(code[i], s, v);
      s_nib[i] = s;
      if (i < 3) v_early = v_early | v;
    end
    check({tag, ".v_early"}, 32'(v_early), 32'd0);
    check({tag, ".v"},       32'(v),       32'(exp_v));
    if (!exp_v) check({tag, ".s"}, 32'(s_nib), 32'(exp_dig));
    idle;
    check_digit_outputs(tag, exp_dig, exp_v, exp_wd, exp_err);
    idle;
    check({tag, ".done_clr"}, 32'(obs_done), 32'd0);
  endtask

  initial begin
    logic s;
    logic v;
    logic [3:0] s_nib;

    en   = 1'b0;
    x    = 1'b0;
    sel  = 1'b0;
    ClrN = 1'b0;
    #12;
    check("rst.digit", 32'(if1.Digit), 32'd0);
    check("rst.done",  32'(if1.Done),  32'd0);
    check("rst.derr",  32'(if1.DErr),  32'd0);
    check("rst.wd",    32'(if1.WordDone), 32'd0);
    check("rst.err",   32'(if1.Err),   32'd0);
    check("rst2.wd",   32'(if2.WordDone), 32'd0);
    ClrN = 1'b1;

    // Boundary valid codes and both invalid ranges, NDIG=1.
    send_digit("c0011", 4'b0011, 4'd0, 1'b0, 1'b1, 1'b0);
    send_digit("c1100", 4'b1100, 4'd9, 1'b0, 1'b1, 1'b0);
    send_digit("c0001", 4'b0001, 4'hF, 1'b1, 1'b1, 1'b1);
    send_digit("c1101", 4'b1101, 4'hF, 1'b1, 1'b1, 1'b1);
    send_digit("c0110", 4'b0110, 4'd3, 1'b0, 1'b1, 1'b0);

    // 0101 with a three-cycle En=0 gap between bits 1 and 2.
    send_bit(1'b1, s, v); s_nib[0] = s;
    send_bit(1'b0, s, v); s_nib[1] = s;
    for (int i = 0; i < 3; i++) begin
      idle;
      check("gap.s",    32'(obs_s),    32'd0);
      check("gap.v",    32'(obs_v),    32'd0);
      check("gap.done", 32'(obs_done), 32'd0);
    end
    send_bit(1'b1, s, v); s_nib[2] = s;
    send_bit(1'b0, s, v); s_nib[3] = s;
    check("gap.s_nib", 32'(s_nib), 32'd2);
    idle;
    check_digit_outputs("gap", 4'd2, 1'b0, 1'b1, 1'b0);
    idle;
    check("gap.single_done", 32'(obs_done), 32'd0);

    // Prime Err/Digit, then reset mid-digit of 0111.
    send_digit("pre", 4'b1111, 4'hF, 1'b1, 1'b1, 1'b1);
    send_bit(1'b1, s, v);
    send_bit(1'b1, s, v);
    @(posedge CLK);
    en   = 1'b0;
    ClrN = 1'b0;
    #1;
    check("mrst.digit", 32'(obs_digit), 32'd0);
    check("mrst.done",  32'(obs_done),  32'd0);
    check("mrst.derr",  32'(obs_derr),  32'd0);
    check("mrst.err",   32'(obs_err),   32'd0);
    #2;
    ClrN = 1'b1;
    idle;
    check("mrst.no_stray_done", 32'(obs_done), 32'd0);
    send_digit("c1000", 4'b1000, 4'd5, 1'b0, 1'b1, 1'b0);

    // Two-digit words.
    sel = 1'b1;
    send_digit("w1d0", 4'b0100, 4'd1, 1'b0, 1'b0, 1'b0);
    send_digit("w1d1", 4'b1111, 4'hF, 1'b1, 1'b1, 1'b1);
    send_digit("w2d0", 4'b0110, 4'd3, 1'b0, 1'b0, 1'b0);
    send_digit("w2d1", 4'b0111, 4'd4, 1'b0, 1'b1, 1'b0);
    // Error in second digit only of a word still makes the word sticky.
    send_digit("w3d0", 4'b1010, 4'd7, 1'b0, 1'b0, 1'b0);
    send_digit("w3d1", 4'b0010, 4'hF, 1'b1, 1'b1, 1'b1);
    // Error in first digit persists across a clean second digit.
    send_digit("w4d0", 4'b0000, 4'hF, 1'b1, 1'b0, 1'b1);
    send_digit("w4d1", 4'b1011, 4'd8, 1'b0, 1'b1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
